serial_mag_comp: RTL and testbench

//  Multi-bit magnitude comparator that examines operands DIGIT bits per cycle, MSB-first.
//  It stops early at the first differing digit and supports unsigned or two's-complement mode.

---
 rtl/serial_mag_comp_if.sv | 36 +++
 rtl/serial_mag_comp.sv | 136 +++++++++++++
 tb/tb_serial_mag_comp.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_mag_comp_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_mag_comp_if
//  Description : Handshake and operand bundle for the serial magnitude
//                comparator. The master drives a request (start/abort/mode
//                plus operands); the slave returns busy/done and the held
//                lt/eq/gt result.
//  Ports       : start_i, abort_i, signed_i, a_i[WIDTH], b_i[WIDTH]  (m -> s)
//                busy_o, done_o, lt_o, eq_o, gt_o                    (s -> m)
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_mag_comp_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic             abort_i;
    logic             signed_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic             lt_o;
    logic             eq_o;
    logic             gt_o;

    modport master (
        output start_i, abort_i, signed_i, a_i, b_i,
        input  busy_o, done_o, lt_o, eq_o, gt_o
    );

    modport slave (
        input  start_i, abort_i, signed_i, a_i, b_i,
        output busy_o, done_o, lt_o, eq_o, gt_o
    );
endinterface
`default_nettype wire

// File: rtl/serial_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module      : serial_mag_comp
//  Description : Digit-serial magnitude comparator. Compares DIGIT bits per
//                cycle, MSB first, and stops at the first differing digit.
//                Two's-complement mode is handled by flipping both operand
//                MSBs at load (offset binary), so the digit compare itself is
//                always unsigned.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - slave side of serial_mag_comp_if
//                         (start/abort/signed/a/b in, busy/done/lt/eq/gt out)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_mag_comp #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_mag_comp_if.slave   bus
);
    localparam int                N       = WIDTH / DIGIT;
    localparam int                CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0]  C_MSB   = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

    logic [DIGIT-1:0]   w_da, w_db;
    logic [WIDTH-1:0]   w_a_shift, w_b_shift;
    logic [WIDTH-1:0]   w_flip;

    // The mode is only consulted at load time, so it is effectively latched
    // into the operand encoding and later signed_i changes are harmless.
    assign w_flip = ((SIGNED_EN != 0) && bus.signed_i) ? C_MSB : '0;

    assign w_da = a_q[WIDTH-1 -: DIGIT];
    assign w_db = b_q[WIDTH-1 -: DIGIT];

    // With a single digit there is never a shift; avoid a zero-width slice.
    generate
        if (N > 1) begin : g_multi
            assign w_a_shift = {a_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
            assign w_b_shift = {b_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
        end else begin : g_single
            assign w_a_shift = '0;
            assign w_b_shift = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;

        if (bus.abort_i) begin
            // Abort wins over everything, including a coincident start;
            // the previously published result is left untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start_i) begin
                        a_d     = bus.a_i ^ w_flip;
                        b_d     = bus.b_i ^ w_flip;
                        cnt_d   = '0;
                        state_d = S_CMP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CMP: begin
                    if (w_da != w_db) begin
                        lt_d    = (w_da < w_db);
                        gt_d    = (w_da > w_db);
                        eq_d    = 1'b0;
                        state_d = S_DONE;
                    end else if (cnt_q == C_LAST) begin
                        lt_d    = 1'b0;
                        eq_d    = 1'b1;
                        gt_d    = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        a_d   = w_a_shift;
                        b_d   = w_b_shift;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign bus.busy_o = (state_q == S_CMP);
    assign bus.done_o = (state_q == S_DONE);
    assign bus.lt_o   = lt_q;
    assign bus.eq_o   = eq_q;
    assign bus.gt_o   = gt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_mag_comp
//  Description : Bench for serial_mag_comp. Five instances share one stimulus
//                stream: 16/4 signed-capable (main), and 8-bit with DIGIT
//                1, 2, 8 (signed-capable) plus 8/2 unsigned-only. A
//                transaction-level model predicts busy/done/result for each.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_mag_comp;
    localparam int NDUT = 5;

    logic        clk;
    logic        rst_n;
    logic        start, abort, sgn;
    logic [15:0] a16, b16;

    logic [NDUT-1:0] busy_v, done_v, lt_v, eq_v, gt_v;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic int cw(int i); return (i == 0) ? 16 : 8; endfunction
    function automatic int cd(int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : (i == 3) ? 8 : 2;
    endfunction
    function automatic int cs(int i); return (i == 4) ? 0 : 1; endfunction

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            localparam int W = (g == 0) ? 16 : 8;
            localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : (g == 3) ? 8 : 2;
            localparam int S = (g == 4) ? 0 : 1;
            serial_mag_comp_if #(.WIDTH(W)) bus ();
            assign bus.start_i  = start;
            assign bus.abort_i  = abort;
            assign bus.signed_i = sgn;
            assign bus.a_i      = a16[W-1:0];
            assign bus.b_i      = b16[W-1:0];
            serial_mag_comp #(.WIDTH(W), .DIGIT(D), .SIGNED_EN(S)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
            assign busy_v[g] = bus.busy_o;
            assign done_v[g] = bus.done_o;
            assign lt_v[g]   = bus.lt_o;
            assign eq_v[g]   = bus.eq_o;
            assign gt_v[g]   = bus.gt_o;
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Number of digit cycles: index of first differing digit, else N.
    function automatic int pred_k(int w, int d, logic [15:0] a, logic [15:0] b);
        int n   = w / d;
        int msk = (1 << d) - 1;
        for (int i = 0; i < n; i++) begin
            int sh = w - d * (i + 1);
            if (((int'(a) >> sh) & msk) != ((int'(b) >> sh) & msk)) return i + 1;
        end
        return n;
    endfunction

    // {lt,eq,gt} from plain integer comparison.
    function automatic logic [2:0] pred_res(int w, bit s, logic [15:0] a, logic [15:0] b);
        int av = int'(a) & ((1 << w) - 1);
        int bv = int'(b) & ((1 << w) - 1);
        if (s && av >= (1 << (w - 1))) av -= (1 << w);
        if (s && bv >= (1 << (w - 1))) bv -= (1 << w);
        if (av < bv) return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    int         m_state [NDUT];   // 0 idle, 1 busy, 2 done
    int         m_rem   [NDUT];
    logic [2:0] m_res   [NDUT];
    logic [2:0] m_pend  [NDUT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDUT; i++) begin
                m_state[i] <= 0;
                m_rem[i]   <= 0;
                m_res[i]   <= 3'b000;
                m_pend[i]  <= 3'b000;
            end
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                if (abort) begin
                    m_state[i] <= 0;
                end else if (m_state[i] != 1 && start) begin
                    m_state[i] <= 1;
                    m_rem[i]   <= pred_k(cw(i), cd(i), a16, b16);
                    m_pend[i]  <= pred_res(cw(i), (cs(i) != 0) && sgn, a16, b16);
                end else if (m_state[i] == 1) begin
                    if (m_rem[i] == 1) begin
                        m_state[i] <= 2;
                        m_res[i]   <= m_pend[i];
                    end else begin
                        m_rem[i] <= m_rem[i] - 1;
                    end
                end else begin
                    m_state[i] <= 0;
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_state[i] == 1));
                chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_state[i] == 2));
                chk($sformatf("res[%0d]", i), 32'({lt_v[i], eq_v[i], gt_v[i]}), 32'(m_res[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // One start pulse; measures busy length of the main instance and checks
    // it, the result, and the model's own prediction against literals.
    task automatic run(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input int exp_k, input logic [2:0] exp_res);
        int  cnt;
        bit  seen;
        chk({nm, "_model_k"}, 32'(pred_k(16, 4, a, b)), 32'(exp_k));
        chk({nm, "_model_res"}, 32'(pred_res(16, s, a, b)), 32'(exp_res));
        @(negedge clk);
        start = 1'b1; a16 = a; b16 = b; sgn = s;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done_v[0]) begin
                seen = 1'b1;
                break;
            end
            if (busy_v[0]) cnt++;
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_busy_len"}, 32'(cnt), 32'(exp_k));
        chk({nm, "_res"}, 32'({lt_v[0], eq_v[0], gt_v[0]}), 32'(exp_res));
        repeat (12) @(negedge clk);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sgn = 1'b0;
        a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_state", 32'({busy_v, done_v, lt_v, eq_v, gt_v}), 32'd0);

        run("t1_uns_msb",  16'h8000, 16'h7FFF, 1'b0, 1, 3'b001);
        run("t2_signed",   16'h8000, 16'h0001, 1'b1, 1, 3'b100);
        run("t2_unsigned", 16'h8000, 16'h0001, 1'b0, 1, 3'b001);
        run("t3_equal",    16'h1234, 16'h1234, 1'b0, 4, 3'b010);
        run("t3_lastdig",  16'h1235, 16'h1234, 1'b0, 4, 3'b001);
        run("t3_sgn_neg",  16'hFFFE, 16'hFFFF, 1'b1, 4, 3'b100);

        // Abort on the 2nd busy cycle; start while busy is ignored.
        @(negedge clk);
        start = 1'b1; a16 = 16'h1230; b16 = 16'h1234; sgn = 1'b0;
        @(negedge clk);
        chk("t4_busy1", 32'(busy_v[0]), 32'd1);
        a16 = 16'hFFFF; b16 = 16'h0000;           // must not be re-sampled
        @(negedge clk);
        chk("t4_busy2", 32'(busy_v[0]), 32'd1);
        abort = 1'b1;                              // start still high: ignored
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("t4_aborted", 32'({busy_v[0], done_v[0]}), 32'd0);
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (done_v[0]) seen = 1'b1;
            @(negedge clk);
        end
        chk("t4_no_done", 32'(seen), 32'd0);
        chk("t4_res_held", 32'({lt_v[0], eq_v[0], gt_v[0]}), 32'b100);
        repeat (4) @(negedge clk);

        // Start held through DONE: the next compare begins immediately.
        @(negedge clk);
        start = 1'b1; a16 = 16'h0001; b16 = 16'h0002; sgn = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done_v[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_first_done", 32'(seen), 32'd1);
        chk("t5_first_res", 32'({lt_v[0], eq_v[0], gt_v[0]}), 32'b100);
        a16 = 16'h5000; b16 = 16'h4000;
        @(negedge clk);
        chk("t5_restart_busy", 32'(busy_v[0]), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("t5_second_done", 32'(done_v[0]), 32'd1);
        chk("t5_second_res", 32'({lt_v[0], eq_v[0], gt_v[0]}), 32'b001);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a compare.
        @(negedge clk);
        start = 1'b1; a16 = 16'h1234; b16 = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("t5_pre_rst_busy", 32'(busy_v[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_rst", 32'({busy_v, done_v, lt_v, eq_v, gt_v}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (done_v[0]) seen = 1'b1;
        end
        chk("t5_no_done_after_rst", 32'(seen), 32'd0);

        // Random sweep; the per-cycle compare covers busy length and result.
        for (int it = 0; it < 60; it++) begin
            int mode;
            @(negedge clk);
            a16  = 16'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0)      b16 = 16'($urandom);
            else if (mode == 1) b16 = a16;
            else                b16 = a16 ^ (16'd1 << $urandom_range(0, 15));
            sgn   = 1'($urandom_range(0, 1));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            sgn   = ~sgn;                          // mid-op mode change: no effect
            repeat (16) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
